// File: rtl/event_resync_pkg.sv
// ---------------------------------------------------------------------------
// event_resync_pkg
// Shared definitions for the event resynchroniser:
//   mode_e      - 2-bit per-channel edge select (rise / fall / both / off)
//   edge_match  - decides whether a level transition produces an event
// ---------------------------------------------------------------------------
package event_resync_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'd0,
    MODE_FALL = 2'd1,
    MODE_BOTH = 2'd2,
    MODE_OFF  = 2'd3
  } mode_e;

  // A level update is a rise when the new level is 1, a fall when it is 0.
  function automatic logic edge_match(input mode_e mode, input logic new_level);
    logic match;
    unique case (mode)
      MODE_RISE: match = new_level;
      MODE_FALL: match = ~new_level;
      MODE_BOTH: match = 1'b1;
      default:   match = 1'b0;
    endcase
    return match;
  endfunction

endpackage

// File: rtl/event_resync_chan.sv
// ---------------------------------------------------------------------------
// event_resync_chan
// One independent channel: DEPTH-flop synchroniser, glitch filter that only
// accepts a new level after it has been stable for max(FILTER,1) cycles,
// edge detection against the selected mode, and sticky pending/overrun flags.
//
// Ports
//   clk, rst     - clock, asynchronous active-high reset
//   sig_i        - asynchronous input
//   mode_i       - edge select for this channel
//   clr_i        - clears pending and overrun
//   level_o      - filtered synchronised level
//   pulse_o      - one-cycle event strobe, high in the cycle the level changes
//   pending_o    - sticky event flag
//   overrun_o    - sticky flag: an event arrived while pending was still set
// ---------------------------------------------------------------------------
module event_resync_chan
  import event_resync_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int FILTER = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sig_i,
  input  mode_e mode_i,
  input  logic  clr_i,
  output logic  level_o,
  output logic  pulse_o,
  output logic  pending_o,
  output logic  overrun_o
);

  // FILTER values 0 and 1 both mean "accept after one cycle".
  localparam int FLT   = (FILTER < 1) ? 1 : FILTER;
  localparam int CNT_W = (FILTER <= 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLT - 1);

  logic [DEPTH-1:0] sync_q;
  logic             sync_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             update;

  assign sync_s = sync_q[DEPTH-1];

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_s;
      cnt_d   = '0;
      update  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Mode is sampled at the same edge the level updates.
    pulse_d   = update & edge_match(mode_i, sync_s);
    // A pulse beats a simultaneous clear for both sticky flags.
    pending_d = (pending_q & ~clr_i) | pulse_q;
    overrun_d = (pulse_q & pending_q) | (overrun_q & ~clr_i);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values; the sync chain is ordinary flops (not a memory) and
  // is reset with everything else, which is what turns an input held high
  // through reset into a rise event after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[DEPTH-2:0], sig_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/event_resync.sv
// ---------------------------------------------------------------------------
// event_resync
// WIDTH independent asynchronous event inputs, each synchronised, glitch
// filtered and edge detected; a single registered interrupt is the OR of all
// pending flags.
//
// Ports
//   clk      - clock
//   rst      - asynchronous active-high reset
//   sig      - [WIDTH]    asynchronous channel inputs
//   mode     - [2*WIDTH]  edge select, bits [2i+1:2i] for channel i
//   clr      - [WIDTH]    clear pending/overrun per channel
//   level    - [WIDTH]    filtered synchronised level
//   pulse    - [WIDTH]    one-cycle event strobe
//   pending  - [WIDTH]    sticky event flag
//   overrun  - [WIDTH]    sticky lost-event flag
//   irq      - registered OR of pending
// ---------------------------------------------------------------------------
module event_resync
  import event_resync_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter int FILTER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sig,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   pending,
  output logic [WIDTH-1:0]   overrun,
  output logic               irq
);

  logic irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    event_resync_chan #(
      .DEPTH  (DEPTH),
      .FILTER (FILTER)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .sig_i     (sig[i]),
      .mode_i    (mode_e'(mode[2*i +: 2])),
      .clr_i     (clr[i]),
      .level_o   (level[i]),
      .pulse_o   (pulse[i]),
      .pending_o (pending[i]),
      .overrun_o (overrun[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |pending;
  end

  assign irq = irq_q;

endmodule
